gear_status_display: RTL and testbench

//  Reader side of the gear-selector status bus. Consumes the 7-bit one-hot status word
//  {R1,N1,P1,D4,D3,D2,D1} produced by the selector FSM. Filters transition glitches,

---
 rtl/gear_status_display.sv | 177 +++++++++++++++++
 tb/tb_gear_status_display.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gear_status_display.sv
// Gear-selector status bus reader: glitch-filters the one-hot status word, validates it,
// and drives a 7-segment digit plus binary gear code, change strobe and fault flag.
module gear_status_display #(
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_CYCLES  = 16,
  parameter int BLINK_BIT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] status,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] gear_code,
  output logic       change_pulse,
  output logic       fault
);

  localparam int CW     = $clog2(STABLE_CYCLES + 1);
  localparam int BW_RAW = $clog2(BLINK_CYCLES + 1);
  localparam int BW     = (BW_RAW > BLINK_BIT) ? BW_RAW : BLINK_BIT + 1;

  localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  localparam logic [2:0] CODE_NONE = 3'd7;
  localparam logic [2:0] CODE_D1   = 3'd3;

  localparam logic [6:0] GLYPH_P    = 7'b1110011;
  localparam logic [6:0] GLYPH_R    = 7'b1010000;
  localparam logic [6:0] GLYPH_N    = 7'b1010100;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_E    = 7'b1111001;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLINK,
    FAULT
  } state_t;

  function automatic logic [2:0] decodeWord(input logic [6:0] w);
    logic [2:0] code;
    case (w)
      7'b0010000: code = 3'd0;
      7'b1000000: code = 3'd1;
      7'b0100000: code = 3'd2;
      7'b0000001: code = 3'd3;
      7'b0000010: code = 3'd4;
      7'b0000100: code = 3'd5;
      7'b0001000: code = 3'd6;
      default:    code = CODE_NONE;
    endcase
    return code;
  endfunction

  function automatic logic [6:0] glyphOf(input logic [2:0] code);
    logic [6:0] g;
    case (code)
      3'd0:    g = GLYPH_P;
      3'd1:    g = GLYPH_R;
      3'd2:    g = GLYPH_N;
      3'd3:    g = GLYPH_1;
      3'd4:    g = GLYPH_2;
      3'd5:    g = GLYPH_3;
      3'd6:    g = GLYPH_4;
      default: g = GLYPH_E;
    endcase
    return g;
  endfunction

  logic [6:0]    statusSync_q;
  logic [6:0]    cand_q, cand_d;
  logic [CW-1:0] stableCnt_q, stableCnt_d;
  logic [6:0]    accWord_q;

  state_t        state_q;
  logic [BW-1:0] blinkCnt_q;
  logic [BW-1:0] blinkNext;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [2:0]    code_q;
  logic          pulse_q;
  logic          fault_q;

  logic          acceptHit;
  logic [2:0]    newCode;

  // The extra s_q==cand term demands one more matching sample after the counter saturates,
  // so a word must persist STABLE_CYCLES+1 samples before it is taken.
  always_comb begin
    cand_d      = cand_q;
    stableCnt_d = stableCnt_q;
    if (statusSync_q != cand_q) begin
      cand_d      = statusSync_q;
      stableCnt_d = '0;
    end else if (stableCnt_q != CNT_MAX) begin
      stableCnt_d = stableCnt_q + CW'(1);
    end
  end

  assign acceptHit = (stableCnt_q == CNT_MAX) && (statusSync_q == cand_q) &&
                     (cand_q != accWord_q);
  assign newCode   = decodeWord(cand_q);
  assign blinkNext = blinkCnt_q + BW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      statusSync_q <= '0;
      cand_q       <= '0;
      stableCnt_q  <= '0;
      accWord_q    <= '0;
    end else begin
      statusSync_q <= status;
      cand_q       <= cand_d;
      stableCnt_q  <= stableCnt_d;
      if (acceptHit) begin
        accWord_q <= cand_q;
      end
    end
  end

  // Display FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      blinkCnt_q <= '0;
      seg_q      <= GLYPH_DASH;
      dp_q       <= 1'b0;
      code_q     <= CODE_NONE;
      pulse_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (acceptHit) begin
        if (newCode != CODE_NONE) begin
          code_q     <= newCode;
          dp_q       <= (newCode >= CODE_D1);
          fault_q    <= 1'b0;
          pulse_q    <= (newCode != code_q);
          seg_q      <= glyphOf(newCode);
          blinkCnt_q <= '0;
          if ((state_q == SHOW) || (state_q == BLINK)) begin
            state_q <= BLINK;
          end else begin
            state_q <= SHOW;
          end
        end else begin
          state_q <= FAULT;
          code_q  <= CODE_NONE;
          dp_q    <= 1'b0;
          fault_q <= 1'b1;
          seg_q   <= GLYPH_E;
          pulse_q <= (code_q != CODE_NONE);
        end
      end else if (state_q == BLINK) begin
        if (blinkCnt_q == BLINK_LAST) begin
          state_q <= SHOW;
          seg_q   <= glyphOf(code_q);
        end else begin
          blinkCnt_q <= blinkNext;
          seg_q      <= blinkNext[BLINK_BIT] ? 7'b0000000 : glyphOf(code_q);
        end
      end
    end
  end

  assign seg          = seg_q;
  assign dp           = dp_q;
  assign gear_code    = code_q;
  assign change_pulse = pulse_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_gear_status_display.sv
// Randomized bench for gear_status_display: a behavioural display model is compared
// against the DUT every cycle, with directed scenarios pinned to literal values.
module tb_gear_status_display;

  localparam int STABLE = 4;
  localparam int BLINKN = 16;
  localparam int BBIT   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLINK = 2;
  localparam int M_FAULT = 3;

  localparam logic [6:0] W_P  = 7'b0010000;
  localparam logic [6:0] W_N  = 7'b0100000;
  localparam logic [6:0] W_D1 = 7'b0000001;
  localparam logic [6:0] W_D2 = 7'b0000010;

  localparam logic [6:0] G_P    = 7'b1110011;
  localparam logic [6:0] G_N    = 7'b1010100;
  localparam logic [6:0] G_1    = 7'b0000110;
  localparam logic [6:0] G_2    = 7'b1011011;
  localparam logic [6:0] G_E    = 7'b1111001;
  localparam logic [6:0] G_DASH = 7'b1000000;
  localparam logic [6:0] G_OFF  = 7'b0000000;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] status;
  logic [6:0] seg;
  logic       dp;
  logic [2:0] gear_code;
  logic       change_pulse;
  logic       fault;

  int vectors     = 0;
  int miscompares = 0;

  int         mMode, mCode, mAge, mValid;
  logic       mPulse;
  logic [6:0] mAccWord, runVal, pendWord;
  int         runLen;
  logic       pend;

  gear_status_display #(
    .STABLE_CYCLES(STABLE),
    .BLINK_CYCLES (BLINKN),
    .BLINK_BIT    (BBIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .status      (status),
    .seg         (seg),
    .dp          (dp),
    .gear_code   (gear_code),
    .change_pulse(change_pulse),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  // Gear code for a one-hot status word {R1,N1,P1,D4,D3,D2,D1}; 7 when not one-hot.
  function automatic int codeOfWord(input logic [6:0] w);
    int c;
    c = 7;
    if ($countones(w) == 1) begin
      for (int b = 0; b < 7; b++) begin
        if (w[b]) begin
          if (b <= 3) c = b + 3;
          else if (b == 4) c = 0;
          else if (b == 5) c = 2;
          else c = 1;
        end
      end
    end
    return c;
  endfunction

  function automatic logic [6:0] glyphTab(input int c);
    logic [6:0] g;
    case (c)
      0: g = 7'b1110011;
      1: g = 7'b1010000;
      2: g = 7'b1010100;
      3: g = 7'b0000110;
      4: g = 7'b1011011;
      5: g = 7'b1001111;
      6: g = 7'b1100110;
      default: g = 7'b1111001;
    endcase
    return g;
  endfunction

  function automatic logic [6:0] expSeg();
    logic [6:0] g;
    case (mMode)
      M_IDLE:  g = G_DASH;
      M_SHOW:  g = glyphTab(mCode);
      M_BLINK: g = (((mAge >> BBIT) & 1) == 1) ? G_OFF : glyphTab(mCode);
      default: g = G_E;
    endcase
    return g;
  endfunction

  task automatic modelAccept(input logic [6:0] w);
    int nc;
    nc = codeOfWord(w);
    mAccWord = w;
    if (nc != 7) begin
      mPulse = (nc != mCode);
      mMode  = (mMode == M_SHOW || mMode == M_BLINK) ? M_BLINK : M_SHOW;
      mAge   = 0;
    end else begin
      mPulse = (mCode != 7);
      mMode  = M_FAULT;
    end
    mCode = nc;
  endtask

  // A word is taken one cycle after it has been seen on STABLE+1 consecutive edges.
  initial begin
    mValid = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        mMode = M_IDLE; mCode = 7; mAge = 0; mPulse = 1'b0;
        mAccWord = '0; runVal = '0; runLen = 0; pend = 1'b0; pendWord = '0;
        mValid = 1;
      end else if (mValid == 1) begin
        mPulse = 1'b0;
        if (pend) begin
          modelAccept(pendWord);
        end else if (mMode == M_BLINK) begin
          mAge++;
          if (mAge == BLINKN) mMode = M_SHOW;
        end
        pend = 1'b0;
        if (runLen > 0 && status == runVal) runLen++;
        else begin
          runVal = status;
          runLen = 1;
        end
        if (runLen >= STABLE + 1 && runVal != mAccWord) begin
          pend     = 1'b1;
          pendWord = runVal;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mValid == 1) begin
        logic [6:0] es;
        logic       ed, ef;
        es = expSeg();
        ed = (mCode >= 3 && mCode <= 6);
        ef = (mMode == M_FAULT);
        vectors++;
        if (seg !== es || dp !== ed || gear_code !== 3'(mCode) ||
            change_pulse !== mPulse || fault !== ef) begin
          miscompares++;
          $display("[TB] FAIL model_compare t=%0t got seg=%b dp=%b code=%0d pulse=%b fault=%b, expected seg=%b dp=%b code=%0d pulse=%b fault=%b",
                   $time, seg, dp, gear_code, change_pulse, fault, es, ed, mCode, mPulse, ef);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [6:0] w, input int hold);
    status = w;
    waitCycles(hold);
  endtask

  task automatic checkOutput(input string name, input logic [6:0] eSeg, input logic eDp,
                             input logic [2:0] eCode, input logic ePulse, input logic eFault);
    vectors++;
    if (seg !== eSeg || dp !== eDp || gear_code !== eCode ||
        change_pulse !== ePulse || fault !== eFault) begin
      miscompares++;
      $display("[TB] FAIL %s got seg=%b dp=%b code=%0d pulse=%b fault=%b, expected seg=%b dp=%b code=%0d pulse=%b fault=%b",
               name, seg, dp, gear_code, change_pulse, fault, eSeg, eDp, eCode, ePulse, eFault);
    end
  endtask

  initial begin
    reset  = 1'b1;
    status = '0;
    waitCycles(2);
    checkOutput("reset_state", G_DASH, 1'b0, 3'd7, 1'b0, 1'b0);

    // T1: first accept from IDLE shows P with a pulse and no blink
    reset = 1'b0;
    applyStimulus(W_P, 5);
    checkOutput("t1_before_accept", G_DASH, 1'b0, 3'd7, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t1_accept", G_P, 1'b0, 3'd0, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("t1_pulse_drop", G_P, 1'b0, 3'd0, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("t1_no_blink", G_P, 1'b0, 3'd0, 1'b0, 1'b0);

    // T2: short glitch ignored
    applyStimulus(W_D1, 2);
    applyStimulus(W_P, 10);
    checkOutput("t2_glitch_ignored", G_P, 1'b0, 3'd0, 1'b0, 1'b0);

    // T3: P -> D1 with blink phase
    applyStimulus(W_D1, 6);
    checkOutput("t3_accept", G_1, 1'b1, 3'd3, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("t3_blink_off", G_OFF, 1'b1, 3'd3, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("t3_blink_on", G_1, 1'b1, 3'd3, 1'b0, 1'b0);
    waitCycles(7);
    checkOutput("t3_last_off", G_OFF, 1'b1, 3'd3, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t3_steady", G_1, 1'b1, 3'd3, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("t3_still_steady", G_1, 1'b1, 3'd3, 1'b0, 1'b0);

    // T4: fault entry and recovery
    applyStimulus(7'b0000011, 6);
    checkOutput("t4_fault", G_E, 1'b0, 3'd7, 1'b1, 1'b1);
    waitCycles(1);
    checkOutput("t4_fault_hold", G_E, 1'b0, 3'd7, 1'b0, 1'b1);
    applyStimulus(W_N, 6);
    checkOutput("t4_recover", G_N, 1'b0, 3'd2, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("t4_no_blink", G_N, 1'b0, 3'd2, 1'b0, 1'b0);

    // T5: reset during blink, then re-accept via IDLE
    applyStimulus(W_D2, 6);
    checkOutput("t5_blink_start", G_2, 1'b1, 3'd4, 1'b1, 1'b0);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("t5_reset", G_DASH, 1'b0, 3'd7, 1'b0, 1'b0);
    reset = 1'b0;
    waitCycles(5);
    checkOutput("t5_wait", G_DASH, 1'b0, 3'd7, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t5_reaccept", G_2, 1'b1, 3'd4, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("t5_no_blink", G_2, 1'b1, 3'd4, 1'b0, 1'b0);

    // T6: new gear during blink restarts the blink with the new glyph
    applyStimulus(W_D1, 6);
    checkOutput("t6_blink_d1", G_1, 1'b1, 3'd3, 1'b1, 1'b0);
    applyStimulus(W_D2, 5);
    checkOutput("t6_d1_off", G_OFF, 1'b1, 3'd3, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t6_restart", G_2, 1'b1, 3'd4, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("t6_off", G_OFF, 1'b1, 3'd4, 1'b0, 1'b0);
    waitCycles(11);
    checkOutput("t6_last_off", G_OFF, 1'b1, 3'd4, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("t6_steady", G_2, 1'b1, 3'd4, 1'b0, 1'b0);

    // Random words and hold times with occasional resets, checked by the model
    for (int i = 0; i < 400; i++) begin
      logic [6:0] w;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6) w = 7'(1 << sel);
      else if (sel == 7) w = '0;
      else if (sel == 8) w = 7'($urandom);
      else w = 7'((1 << $urandom_range(0, 6)) | (1 << $urandom_range(0, 6)));
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
      end
      applyStimulus(w, $urandom_range(1, 10));
    end
    waitCycles(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
